// File: rtl/match_controller.sv
// Pong match controller: synchronises frame/point strobes, decodes key presses,
// and sequences idle/serve/play/pause/point/over while keeping both scores.
module match_controller #(
  parameter int unsigned WIN_SCORE    = 9,
  parameter int unsigned SERVE_FRAMES = 60
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  input  logic       pointL,
  input  logic       pointR,
  output logic [3:0] scoreL,
  output logic [3:0] scoreR,
  output logic       freeze,
  output logic       serve,
  output logic       serve_dir,
  output logic [2:0] game_state,
  output logic [1:0] winner
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_PAUSE = 3'd3,
    S_POINT = 3'd4,
    S_OVER  = 3'd5
  } state_t;

  localparam logic [7:0] KEY_START   = 8'h2C;
  localparam logic [7:0] KEY_PAUSE   = 8'h13;
  localparam logic [7:0] KEY_RESTART = 8'h28;
  localparam logic [3:0] WIN         = 4'(WIN_SCORE);
  localparam logic [7:0] CD_LOAD     = 8'(SERVE_FRAMES);

  // Bit 0 frame_clk, bit 1 pointL, bit 2 pointR share one sync/edge pipeline.
  logic [2:0] async_in;
  logic [2:0] s1_q, s2_q, s3_q, edge_q, edge_d;

  assign async_in = {pointR, pointL, frame_clk};

  always_comb begin
    edge_d = s2_q & ~s3_q;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      s1_q   <= '0;
      s2_q   <= '0;
      s3_q   <= '0;
      edge_q <= '0;
    end else begin
      s1_q   <= async_in;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      edge_q <= edge_d;
    end
  end

  logic tick, ev_l, ev_r;
  assign tick = edge_q[0];
  assign ev_l = edge_q[1];
  assign ev_r = edge_q[2];

  logic [7:0] key_q, key_prev_q;
  logic       key_new, start_ev, pause_ev, restart_ev;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      key_q      <= '0;
      key_prev_q <= '0;
    end else begin
      key_q      <= keycode;
      key_prev_q <= key_q;
    end
  end

  assign key_new    = (key_q != key_prev_q);
  assign start_ev   = key_new && (key_q == KEY_START);
  assign pause_ev   = key_new && (key_q == KEY_PAUSE);
  assign restart_ev = key_new && (key_q == KEY_RESTART);

  state_t     state_q, state_d;
  logic [7:0] cd_q, cd_d;
  logic       lat_l_q, lat_l_d, lat_r_q, lat_r_d;
  logic [3:0] score_l_q, score_l_d, score_r_q, score_r_d;
  logic       dir_q, dir_d;
  logic [1:0] winner_q, winner_d;
  logic       serve_q, serve_d;
  logic       freeze_q, freeze_d;
  logic       win_hit;

  always_comb begin
    state_d   = state_q;
    cd_d      = cd_q;
    lat_l_d   = lat_l_q;
    lat_r_d   = lat_r_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    dir_d     = dir_q;
    winner_d  = winner_q;
    serve_d   = 1'b0;
    win_hit   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_ev) begin
          state_d = S_SERVE;
          cd_d    = CD_LOAD;
        end
      end
      S_SERVE: begin
        if (tick) begin
          if (cd_q <= 8'd1) begin
            cd_d    = '0;
            state_d = S_PLAY;
            serve_d = 1'b1;
          end else begin
            cd_d = cd_q - 8'd1;
          end
        end
      end
      S_PLAY: begin
        if (ev_l || ev_r) begin
          lat_l_d = ev_l;
          lat_r_d = ev_r;
          state_d = S_POINT;
        end else if (pause_ev) begin
          state_d = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (pause_ev) state_d = S_PLAY;
      end
      S_POINT: begin
        // Simultaneous points cancel out: neither branch fires, so a let is replayed.
        if (lat_l_q && !lat_r_q) begin
          score_l_d = score_l_q + 4'd1;
          dir_d     = 1'b1;
          win_hit   = (score_l_d == WIN);
        end else if (lat_r_q && !lat_l_q) begin
          score_r_d = score_r_q + 4'd1;
          dir_d     = 1'b0;
          win_hit   = (score_r_d == WIN);
        end
        if (win_hit) begin
          state_d  = S_OVER;
          winner_d = lat_l_q ? 2'b01 : 2'b10;
        end else begin
          state_d = S_SERVE;
          cd_d    = CD_LOAD;
        end
        lat_l_d = 1'b0;
        lat_r_d = 1'b0;
      end
      S_OVER: begin
        if (restart_ev) begin
          score_l_d = '0;
          score_r_d = '0;
          winner_d  = '0;
          dir_d     = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    freeze_d = (state_d != S_PLAY);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      cd_q      <= '0;
      lat_l_q   <= 1'b0;
      lat_r_q   <= 1'b0;
      score_l_q <= '0;
      score_r_q <= '0;
      dir_q     <= 1'b0;
      winner_q  <= '0;
      serve_q   <= 1'b0;
      freeze_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      cd_q      <= cd_d;
      lat_l_q   <= lat_l_d;
      lat_r_q   <= lat_r_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
      dir_q     <= dir_d;
      winner_q  <= winner_d;
      serve_q   <= serve_d;
      freeze_q  <= freeze_d;
    end
  end

  assign scoreL     = score_l_q;
  assign scoreR     = score_r_q;
  assign freeze     = freeze_q;
  assign serve      = serve_q;
  assign serve_dir  = dir_q;
  assign game_state = state_q;
  assign winner     = winner_q;

endmodule

// File: tb/tb_match_controller.sv
// Self-checking bench for match_controller: directed scenarios plus random
// stimulus, compared every cycle against a rule-level game model.
module tb_match_controller;

  localparam int WIN = 9;
  localparam int SF  = 60;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       frame_clk = 1'b0;
  logic [7:0] keycode = 8'h00;
  logic       pointL = 1'b0;
  logic       pointR = 1'b0;
  logic [3:0] scoreL, scoreR;
  logic       freeze, serve, serve_dir;
  logic [2:0] game_state;
  logic [1:0] winner;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 Clk = ~Clk;

  match_controller #(.WIN_SCORE(WIN), .SERVE_FRAMES(SF)) dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .keycode(keycode),
    .pointL(pointL), .pointR(pointR), .scoreL(scoreL), .scoreR(scoreR),
    .freeze(freeze), .serve(serve), .serve_dir(serve_dir),
    .game_state(game_state), .winner(winner)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural game model ----------------
  // Modes: 0 idle, 1 serve countdown, 2 play, 3 pause, 4 point, 5 over.
  int   m_mode, m_sl, m_sr, m_win, m_cd;
  bit   m_dir, m_serve, m_lat_l, m_lat_r;
  bit   [3:0] fc_h, pl_h, pr_h;   // bit k = input sampled k+1 edges ago
  logic [7:0] kc_h0, kc_h1;

  task automatic model_reset();
    m_mode = 0; m_sl = 0; m_sr = 0; m_win = 0; m_cd = 0;
    m_dir = 0; m_serve = 0; m_lat_l = 0; m_lat_r = 0;
    fc_h = '0; pl_h = '0; pr_h = '0; kc_h0 = '0; kc_h1 = '0;
  endtask

  task automatic model_step();
    bit tick, evl, evr, k_start, k_pause, k_restart, scored;
    // A level rising before edge n is seen by the game on edge n+3.
    tick = fc_h[2] && !fc_h[3];
    evl  = pl_h[2] && !pl_h[3];
    evr  = pr_h[2] && !pr_h[3];
    k_start   = (kc_h0 == 8'h2C) && (kc_h1 != kc_h0);
    k_pause   = (kc_h0 == 8'h13) && (kc_h1 != kc_h0);
    k_restart = (kc_h0 == 8'h28) && (kc_h1 != kc_h0);
    m_serve = 0;
    if (m_mode == 0) begin
      if (k_start) begin m_mode = 1; m_cd = SF; end
    end else if (m_mode == 1) begin
      if (tick) begin
        m_cd = m_cd - 1;
        if (m_cd <= 0) begin m_mode = 2; m_serve = 1; end
      end
    end else if (m_mode == 2) begin
      if (evl || evr) begin m_lat_l = evl; m_lat_r = evr; m_mode = 4; end
      else if (k_pause) m_mode = 3;
    end else if (m_mode == 3) begin
      if (k_pause) m_mode = 2;
    end else if (m_mode == 4) begin
      scored = (m_lat_l != m_lat_r);
      if (m_lat_l && !m_lat_r) begin m_sl++; m_dir = 1; end
      if (m_lat_r && !m_lat_l) begin m_sr++; m_dir = 0; end
      if (scored && (m_sl == WIN || m_sr == WIN)) begin
        m_mode = 5;
        m_win  = (m_sl == WIN) ? 1 : 2;
      end else begin
        m_mode = 1; m_cd = SF;
      end
    end else if (m_mode == 5) begin
      if (k_restart) begin m_sl = 0; m_sr = 0; m_win = 0; m_dir = 0; m_mode = 0; end
    end
    fc_h  = {fc_h[2:0], frame_clk};
    pl_h  = {pl_h[2:0], pointL};
    pr_h  = {pr_h[2:0], pointR};
    kc_h1 = kc_h0;
    kc_h0 = keycode;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge Clk or posedge Reset);
      if (Reset) model_reset();
      else model_step();
    end
  end

  // ---------------- per-cycle compare + serve monitor ----------------
  int serve_cnt = 0;
  bit last_dir, last_frz;

  initial begin
    logic [15:0] act, exp;
    forever begin
      @(negedge Clk);
      act = {game_state, scoreL, scoreR, freeze, serve, serve_dir, winner};
      exp = {3'(m_mode), 4'(m_sl), 4'(m_sr), (m_mode != 2), m_serve, m_dir, 2'(m_win)};
      check("model{state,sL,sR,frz,srv,dir,win}", 32'(act), 32'(exp));
      if (serve === 1'b1) begin
        serve_cnt++;
        last_dir = serve_dir;
        last_frz = freeze;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, expected end of test");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic key(input logic [7:0] k);
    keycode = k; cyc(3); keycode = 8'h00; cyc(2);
  endtask

  task automatic frames(input int n);
    repeat (n) begin frame_clk = 1'b1; cyc(4); frame_clk = 1'b0; cyc(4); end
  endtask

  task automatic point_l();
    pointL = 1'b1; cyc(6); pointL = 1'b0; cyc(2);
  endtask

  task automatic point_r();
    pointR = 1'b1; cyc(6); pointR = 1'b0; cyc(2);
  endtask

  logic [7:0] keys [5] = '{8'h00, 8'h2C, 8'h13, 8'h28, 8'h04};

  initial begin
    int sc;
    int fc_cnt;

    // Reset values
    Reset = 1'b1; cyc(2);
    check("reset_state", 32'(game_state), 32'd0);
    check("reset_freeze", 32'(freeze), 32'd1);
    check("reset_scores", 32'({scoreL, scoreR}), 32'd0);
    check("reset_serve", 32'(serve), 32'd0);
    check("reset_winner", 32'(winner), 32'd0);
    Reset = 1'b0; cyc(2);

    // Start and serve
    key(8'h2C);
    check("start_state", 32'(game_state), 32'd1);
    serve_cnt = 0;
    frames(SF - 1); cyc(8);
    check("no_serve_before_last_tick", 32'(serve_cnt), 32'd0);
    frames(1); cyc(2);
    check("serve_count", 32'(serve_cnt), 32'd1);
    check("serve_dir_first", 32'(last_dir), 32'd0);
    check("freeze_at_serve", 32'(last_frz), 32'd0);
    check("play_state", 32'(game_state), 32'd2);

    // Left point; a second pointL edge during SERVE is discarded
    pointL = 1'b1; frames(3); pointL = 1'b0;
    check("left_scoreL", 32'(scoreL), 32'd1);
    check("left_dir", 32'(serve_dir), 32'd1);
    check("left_state", 32'(game_state), 32'd1);
    check("model_pin_scoreL", 32'(m_sl), 32'd1);
    cyc(2); point_l();
    check("serve_point_ignored", 32'(scoreL), 32'd1);
    frames(SF); cyc(4);
    check("replay_state", 32'(game_state), 32'd2);

    // Simultaneous points -> let
    pointL = 1'b1; pointR = 1'b1; cyc(8); pointL = 1'b0; pointR = 1'b0;
    check("let_scores", 32'({scoreL, scoreR}), 32'h10);
    check("let_dir", 32'(serve_dir), 32'd1);
    check("let_state", 32'(game_state), 32'd1);
    frames(SF); cyc(4);

    // Pause with point ignored, resume without serve
    keycode = 8'h13; cyc(10);
    check("pause_state", 32'(game_state), 32'd3);
    keycode = 8'h00; cyc(2);
    point_r(); cyc(4);
    check("pause_scoreR", 32'(scoreR), 32'd0);
    check("pause_held", 32'(game_state), 32'd3);
    sc = serve_cnt;
    key(8'h13);
    check("resume_state", 32'(game_state), 32'd2);
    check("resume_no_serve", 32'(serve_cnt), 32'(sc));

    // Win and restart
    repeat (7) begin point_l(); frames(SF); cyc(4); end
    check("pre_win_scoreL", 32'(scoreL), 32'd8);
    pointL = 1'b1; cyc(6); pointL = 1'b0;
    check("win_scoreL", 32'(scoreL), 32'd9);
    check("win_winner", 32'(winner), 32'd1);
    check("win_state", 32'(game_state), 32'd5);
    check("win_freeze", 32'(freeze), 32'd1);
    key(8'h2C);
    check("over_space_ignored", 32'(game_state), 32'd5);
    key(8'h28);
    check("restart_state", 32'(game_state), 32'd0);
    check("restart_clear", 32'({scoreL, scoreR, winner, serve_dir}), 32'd0);

    // Reset during countdown with scoreR=4
    key(8'h2C); frames(SF); cyc(4);
    for (int p = 0; p < 4; p++) begin
      point_r();
      if (p < 3) begin frames(SF); cyc(4); end
    end
    frames(10);
    check("pre_reset_scoreR", 32'(scoreR), 32'd4);
    check("pre_reset_state", 32'(game_state), 32'd1);
    #2 Reset = 1'b1;
    #1;
    check("async_reset_scoreR", 32'(scoreR), 32'd0);
    check("async_reset_state", 32'(game_state), 32'd0);
    cyc(2); Reset = 1'b0;
    sc = serve_cnt;
    frames(70);
    check("post_reset_no_serve", 32'(serve_cnt), 32'(sc));
    check("post_reset_idle", 32'(game_state), 32'd0);

    // Randomised play
    fc_cnt = 4;
    for (int i = 0; i < 20000; i++) begin
      @(negedge Clk);
      if ($urandom_range(5) == 0) keycode = keys[$urandom_range(4)];
      if (fc_cnt == 0) begin frame_clk = ~frame_clk; fc_cnt = $urandom_range(6, 3); end
      else fc_cnt--;
      if ($urandom_range(40) == 0) pointL = ~pointL;
      if ($urandom_range(40) == 0) pointR = ~pointR;
      if ($urandom_range(3000) == 0) begin
        #3 Reset = 1'b1;
        @(negedge Clk); @(negedge Clk);
        Reset = 1'b0;
      end
    end
    cyc(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
